// File: rtl/pe_row_mac_array_if.sv
// Handshake and operand bus between the matvec row-block controller (master)
// and the PE row MAC array (slave).
interface pe_row_mac_array_if #(
    parameter int N      = 786,
    parameter int DW     = 16,
    parameter int PE_NUM = 8
);
    logic                                valid;
    logic [PE_NUM-1:0][N-1:0][DW-1:0]    A_block;
    logic [N-1:0][DW-1:0]                x;
    logic [PE_NUM-1:0][2*DW-1:0]         y_out;
    logic [PE_NUM-1:0]                   done_out;
    logic                                busy;

    modport master (
        output valid, A_block, x,
        input  y_out, done_out, busy
    );

    modport slave (
        input  valid, A_block, x,
        output y_out, done_out, busy
    );
endinterface

// File: rtl/pe_row_mac_array.sv
// PE_NUM lockstep signed MAC lanes; each PE accumulates the dot product of
// its A_block row with x, LANES columns per beat, and flags completion.
module pe_row_mac_array #(
    parameter int N      = 786,
    parameter int DW     = 16,
    parameter int PE_NUM = 8,
    parameter int LANES  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    pe_row_mac_array_if.slave   bus
);
    localparam int CW = $clog2(2 * N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] NC = CW'(N);
    localparam logic [CW-1:0] LC = CW'(LANES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_col;
    logic [PE_NUM-1:0]   r_done;
    logic [2*DW-1:0]     r_acc  [PE_NUM];
    logic [2*DW-1:0]     w_beat [PE_NUM];
    logic                w_last;

    // Per-PE sum of this beat's lane products; columns past N contribute 0
    always_comb begin
        logic [CW-1:0]          idx;
        logic signed [2*DW-1:0] a_ext;
        logic signed [2*DW-1:0] x_ext;
        for (int unsigned i = 0; i < PE_NUM; i++) begin
            w_beat[i] = '0;
            for (int unsigned j = 0; j < LANES; j++) begin
                idx   = r_col + CW'(j);
                a_ext = '0;
                x_ext = '0;
                if (idx < NC) begin
                    a_ext = (2*DW)'($signed(bus.A_block[i][IW'(idx)]));
                    x_ext = (2*DW)'($signed(bus.x[IW'(idx)]));
                end
                w_beat[i] = w_beat[i] + (a_ext * x_ext);
            end
        end
    end

    // Final beat when this beat reaches or passes column N
    always_comb begin
        w_last = ((r_col + LC) >= NC);
    end

    // Block FSM: start on valid from IDLE/HOLD, accumulate B beats, then hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_done  <= '0;
            for (int unsigned i = 0; i < PE_NUM; i++) r_acc[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HOLD: begin
                    if (bus.valid) begin
                        r_col   <= '0;
                        r_done  <= '0;
                        r_state <= S_RUN;
                        for (int unsigned i = 0; i < PE_NUM; i++) r_acc[i] <= '0;
                    end
                end
                S_RUN: begin
                    for (int unsigned i = 0; i < PE_NUM; i++) r_acc[i] <= r_acc[i] + w_beat[i];
                    r_col <= r_col + LC;
                    if (w_last) begin
                        r_done  <= '1;
                        r_state <= S_HOLD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Results straight from accumulators; done masked while a new valid is up
    always_comb begin
        for (int unsigned i = 0; i < PE_NUM; i++) bus.y_out[i] = r_acc[i];
        bus.done_out = r_done & {PE_NUM{~bus.valid}};
        bus.busy     = (r_state == S_RUN);
    end
endmodule

// File: tb/tb_pe_row_mac_array.sv
// Directed bench: two DUTs (LANES=1 and LANES=3, N=4, PE_NUM=2) fed the same
// operands, checked against hand-computed dot products and latencies.
module tb_pe_row_mac_array;
    localparam int N      = 4;
    localparam int DW     = 16;
    localparam int PE_NUM = 2;

    logic clk;
    logic rst_n;
    logic valid;
    logic [PE_NUM-1:0][N-1:0][DW-1:0] A;
    logic [N-1:0][DW-1:0]             xv;

    int total;
    int bad;

    pe_row_mac_array_if #(.N(N), .DW(DW), .PE_NUM(PE_NUM)) if1 ();
    pe_row_mac_array_if #(.N(N), .DW(DW), .PE_NUM(PE_NUM)) if3 ();

    assign if1.valid   = valid;
    assign if1.A_block = A;
    assign if1.x       = xv;
    assign if3.valid   = valid;
    assign if3.A_block = A;
    assign if3.x       = xv;

    pe_row_mac_array #(.N(N), .DW(DW), .PE_NUM(PE_NUM), .LANES(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave)
    );
    pe_row_mac_array #(.N(N), .DW(DW), .PE_NUM(PE_NUM), .LANES(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .bus(if3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int r0 [4], input int r1 [4], input int xs [4]);
        for (int j = 0; j < N; j++) begin
            A[0][j] = 16'(r0[j]);
            A[1][j] = 16'(r1[j]);
            xv[j]   = 16'(xs[j]);
        end
    endtask

    // valid in cycle 0; L1 done from cycle 5, L3 done from cycle 3
    task automatic run_block(input string tag, input logic repulse,
                             input logic [31:0] y0, input logic [31:0] y1);
        @(posedge clk); #1 valid = 1'b1;
        @(negedge clk);
        chk({tag, "_l1_done_c0"}, 64'(if1.done_out), 64'(0));
        chk({tag, "_l3_done_c0"}, 64'(if3.done_out), 64'(0));
        @(posedge clk); #1 valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("%s_l1_done_c%0d", tag, c), 64'(if1.done_out), (c >= 5) ? 64'(3) : 64'(0));
            chk($sformatf("%s_l3_done_c%0d", tag, c), 64'(if3.done_out), (c >= 3) ? 64'(3) : 64'(0));
            chk($sformatf("%s_l1_busy_c%0d", tag, c), 64'(if1.busy), (c <= 4) ? 64'(1) : 64'(0));
            chk($sformatf("%s_l3_busy_c%0d", tag, c), 64'(if3.busy), (c <= 2) ? 64'(1) : 64'(0));
            @(posedge clk); #1 valid = repulse && (c == 1);
        end
        @(negedge clk);
        chk({tag, "_l1_y0"}, 64'(if1.y_out[0]), 64'(y0));
        chk({tag, "_l1_y1"}, 64'(if1.y_out[1]), 64'(y1));
        chk({tag, "_l3_y0"}, 64'(if3.y_out[0]), 64'(y0));
        chk({tag, "_l3_y1"}, 64'(if3.y_out[1]), 64'(y1));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        valid = 1'b0;
        rst_n = 1'b0;
        A     = '0;
        xv    = '0;

        #12;
        chk("rst_done",  64'(if1.done_out), 64'(0));
        chk("rst_busy",  64'(if1.busy),     64'(0));
        chk("rst_y0",    64'(if1.y_out[0]), 64'(0));
        chk("rst_l3_y1", 64'(if3.y_out[1]), 64'(0));
        @(negedge clk); rst_n = 1'b1;

        // Basic dot products: {1,2,3,4}.1 = 10, {-1,0,1,0}.1 = 0
        load('{1, 2, 3, 4}, '{-1, 0, 1, 0}, '{1, 1, 1, 1});
        run_block("t1", 1'b0, 32'd10, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("hold_done", 64'(if1.done_out), 64'(3));
        chk("hold_y0",   64'(if1.y_out[0]), 64'(10));

        // Back-to-back from HOLD: 5-(-6)... = 5+6+14-24 = 1 ; 2-2+4+6 = 10
        load('{5, -6, 7, -8}, '{2, 2, 2, 2}, '{1, -1, 2, 3});
        run_block("t4", 1'b0, 32'd1, 32'd10);

        // valid re-pulsed during RUN is ignored
        load('{1, 2, 3, 4}, '{-1, 0, 1, 0}, '{1, 1, 1, 1});
        run_block("t5", 1'b1, 32'd10, 32'd0);

        // Wrap: 4 * 2^30 = 2^32 -> 0 ; 3 * 2^30 -> 0xC0000000
        load('{-32768, -32768, -32768, -32768}, '{-32768, -32768, -32768, 0},
             '{-32768, -32768, -32768, -32768});
        run_block("t3", 1'b0, 32'd0, 32'hC000_0000);

        // Asynchronous reset mid-run (cycle 3)
        load('{1, 2, 3, 4}, '{-1, 0, 1, 0}, '{1, 1, 1, 1});
        @(posedge clk); #1 valid = 1'b1;
        @(posedge clk); #1 valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("t6_pre_y0", 64'(if1.y_out[0]), 64'(3));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_done", 64'(if1.done_out), 64'(0));
        chk("t6_rst_busy", 64'(if1.busy),     64'(0));
        chk("t6_rst_y0",   64'(if1.y_out[0]), 64'(0));
        chk("t6_rst_l3y0", 64'(if3.y_out[0]), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        run_block("t6", 1'b0, 32'd10, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
